fetch_u: RTL and testbench
==========================

FETCH_U -- requirements
Module: fetch_u

Interface
REQ-001 Parameter RESET_PC, default 32'h0001_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), instruction placed in IF/ID on flush/reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 interlock  input  1  pipeline stall from the interlock unit; 1 = hold all fetch state.
REQ-006 branch_taken  input  1  redirect request from execute stage.
REQ-007 branch_target  input  32  redirect address, valid when branch_taken=1.
REQ-008 imem_data  input  32  instruction word returned by instruction memory for imem_addr.
REQ-009 imem_addr  output  32  fetch address, combinationally equal to current pc register.
REQ-010 pc_if_id  output  32  registered PC of instruction in IF/ID.
REQ-011 inst_if_id  output  32  registered instruction in IF/ID.
REQ-012 valid_if_id  output  1  registered; 1 = inst_if_id is a real fetched instruction, 0 = bubble.

Function
REQ-013 Internal state: pc (32), pending_target (32), FSM state in {RUN, REDIRECT_PENDING}.
REQ-014 imem_addr SHALL equal pc at all times; no added latency.
REQ-015 RUN, interlock=0, branch_taken=0: pc <= pc+4; pc_if_id <= pc; inst_if_id <= imem_data; valid_if_id <= 1.
REQ-016 RUN, interlock=0, branch_taken=1: pc <= {branch_target[31:2],2'b00}; inst_if_id <= NOP_INST; valid_if_id <= 0; pc_if_id <= pc; state stays RUN.
REQ-017 RUN, interlock=1, branch_taken=0: pc, pc_if_id, inst_if_id, valid_if_id all hold.
REQ-018 RUN, interlock=1, branch_taken=1: pc and IF/ID hold; pending_target <= {branch_target[31:2],2'b00}; state -> REDIRECT_PENDING.
REQ-019 REDIRECT_PENDING, interlock=1: pc and IF/ID hold; if branch_taken=1, pending_target overwritten with new aligned target (newest wins); else pending_target holds.
REQ-020 REDIRECT_PENDING, interlock=0, branch_taken=0: pc <= pending_target; IF/ID flushed (NOP_INST, valid 0); state -> RUN.
REQ-021 REDIRECT_PENDING, interlock=0, branch_taken=1: pc <= aligned branch_target (live input beats pending); IF/ID flushed; state -> RUN.
REQ-022 PC increment SHALL be modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-023 Branch target bits [1:0] SHALL be cleared before use; no exception raised.
REQ-024 Redirect SHALL never be lost: every branch_taken=1 cycle results in pc equal to the latest target on the first non-interlocked cycle at or after it.
REQ-025 imem_data SHALL be sampled only in REQ-015 cycles; its value is don't-care otherwise.

Reset
REQ-026 rst=1 at a rising edge: pc <= RESET_PC; pc_if_id <= RESET_PC; inst_if_id <= NOP_INST; valid_if_id <= 0; pending_target <= 0; state -> RUN.
REQ-027 rst SHALL take priority over interlock and branch_taken, including mid-REDIRECT_PENDING (pending redirect discarded).
REQ-028 First edge after rst deasserts with interlock=0 SHALL fetch from RESET_PC per REQ-015.

Verification
REQ-029 Sequential fetch: rst 1 cycle, interlock=0, imem_data=32'h0000_0093 -> imem_addr 0x00010000, 0x00010004, 0x00010008 on successive cycles; pc_if_id lags by one cycle, valid_if_id=1.
REQ-030 Stall: interlock=1 for 3 cycles at pc=0x00010008 -> imem_addr, pc_if_id, inst_if_id, valid_if_id unchanged for 3 cycles, then advance to 0x0001000C.
REQ-031 Branch: branch_taken=1, branch_target=0x00010103, interlock=0 -> next cycle imem_addr=0x00010100, inst_if_id=0x00000013, valid_if_id=0.
REQ-032 Branch during stall: interlock=1, branch_taken=1 target 0x00020000 then next cycle target 0x00030000, interlock drops a cycle later -> pc holds during stall, then imem_addr=0x00030000, IF/ID flushed.
REQ-033 Wrap: pc forced via branch to 0xFFFFFFFC, interlock=0 -> next imem_addr=0x00000000, pc_if_id=0xFFFFFFFC.
REQ-034 Reset mid-pending: enter REDIRECT_PENDING (target 0x00020000), assert rst with interlock=1 -> imem_addr=0x00010000, valid_if_id=0; after release no jump to 0x00020000.

Source files
------------

// File: rtl/fetch_u_if.sv
// rtl/fetch_u_if.sv - fetch unit bus bundle: control inputs, imem port and IF/ID outputs
interface fetch_u_if;
  logic        interlock;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_if_id;
  logic [31:0] inst_if_id;
  logic        valid_if_id;

  modport master (
    input  interlock, branch_taken, branch_target, imem_data,
    output imem_addr, pc_if_id, inst_if_id, valid_if_id
  );

  modport slave (
    output interlock, branch_taken, branch_target, imem_data,
    input  imem_addr, pc_if_id, inst_if_id, valid_if_id
  );
endinterface

// File: rtl/fetch_u.sv
// rtl/fetch_u.sv - instruction fetch stage with IF/ID register and deferred redirect
module fetch_u #(
  parameter logic [31:0] RESET_PC = 32'h0001_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  fetch_u_if.master  bus
);

  typedef enum logic {RUN, REDIRECT_PENDING} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] pc_if_id_q, pc_if_id_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] target_aligned;

  assign target_aligned = {bus.branch_target[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    pc_if_id_d = pc_if_id_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    case (state_q)
      RUN: begin
        if (!bus.interlock) begin
          pc_if_id_d = pc_q;
          if (bus.branch_taken) begin
            pc_d    = target_aligned;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end else begin
            pc_d    = pc_q + 32'd4;
            inst_d  = bus.imem_data;
            valid_d = 1'b1;
          end
        end else if (bus.branch_taken) begin
          // Redirect arrives while stalled: remember it until the stall clears.
          pending_d = target_aligned;
          state_d   = REDIRECT_PENDING;
        end
      end
      REDIRECT_PENDING: begin
        if (bus.interlock) begin
          if (bus.branch_taken) begin
            pending_d = target_aligned;
          end
        end else begin
          // A live redirect is younger than the stored one, so it wins.
          pc_d       = bus.branch_taken ? target_aligned : pending_q;
          pc_if_id_d = pc_q;
          inst_d     = NOP_INST;
          valid_d    = 1'b0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pending_q  <= 32'h0;
      pc_if_id_q <= RESET_PC;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      pc_if_id_q <= pc_if_id_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc_if_id    = pc_if_id_q;
  assign bus.inst_if_id  = inst_q;
  assign bus.valid_if_id = valid_q;

endmodule

// File: tb/tb_fetch_u.sv
// tb/tb_fetch_u.sv - directed vector table plus randomized run against a redirect-queue model
module tb_fetch_u;
  localparam logic [31:0] RPC = 32'h0001_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_u_if bus();

  fetch_u dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        il;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [31:0] e_pcid;
    logic        chk_pcid;
    logic [31:0] e_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic il, input logic bt, input logic [31:0] tgt,
                     input logic [31:0] data, input logic [31:0] ea, input logic [31:0] ep,
                     input logic cp, input logic [31:0] ei, input logic ev);
    vec_t v;
    v.rst = r; v.il = il; v.bt = bt; v.tgt = tgt; v.data = data;
    v.e_addr = ea; v.e_pcid = ep; v.chk_pcid = cp; v.e_inst = ei; v.e_valid = ev;
    vecs.push_back(v);
  endtask

  // Behavioural model: state is the architectural view plus a list of owed redirects.
  logic [31:0] m_pc, m_pcid, m_inst;
  logic        m_valid, m_pcid_known;
  logic [31:0] owed[$];

  task automatic model_step(input logic r, input logic il, input logic bt,
                            input logic [31:0] tgt, input logic [31:0] data);
    logic [31:0] a;
    a = tgt & 32'hFFFF_FFFC;
    if (r) begin
      m_pc = RPC; m_pcid = RPC; m_inst = NOP; m_valid = 1'b0; m_pcid_known = 1'b1;
      owed.delete();
    end else if (il) begin
      if (bt) owed.push_back(a);
    end else if (bt || owed.size() > 0) begin
      m_pcid_known = (owed.size() == 0);
      m_pcid = m_pc;
      m_pc = bt ? a : owed[owed.size()-1];
      m_inst = NOP; m_valid = 1'b0;
      owed.delete();
    end else begin
      m_pcid = m_pc; m_pcid_known = 1'b1;
      m_pc = m_pc + 32'd4;
      m_inst = data; m_valid = 1'b1;
    end
  endtask

  task automatic drive(input logic r, input logic il, input logic bt,
                       input logic [31:0] tgt, input logic [31:0] data);
    @(negedge clk);
    rst = r; bus.interlock = il; bus.branch_taken = bt;
    bus.branch_target = tgt; bus.imem_data = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.interlock = 1'b0; bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0; bus.imem_data = 32'h0;

    //   rst il bt target        data          addr          pc_if_id      chk inst          valid
    add(1, 0, 0, 32'h0,        32'h93,        32'h00010000, 32'h00010000, 1, NOP,          0);
    add(0, 0, 0, 32'h0,        32'h93,        32'h00010004, 32'h00010000, 1, 32'h93,       1);
    add(0, 0, 0, 32'h0,        32'h93,        32'h00010008, 32'h00010004, 1, 32'h93,       1);
    add(0, 1, 0, 32'h0,        32'hDEAD,      32'h00010008, 32'h00010004, 1, 32'h93,       1);
    add(0, 1, 0, 32'h0,        32'hBEEF,      32'h00010008, 32'h00010004, 1, 32'h93,       1);
    add(0, 1, 0, 32'h0,        32'hF00D,      32'h00010008, 32'h00010004, 1, 32'h93,       1);
    add(0, 0, 0, 32'h0,        32'h93,        32'h0001000C, 32'h00010008, 1, 32'h93,       1);
    add(0, 0, 1, 32'h00010103, 32'h55,        32'h00010100, 32'h0001000C, 1, NOP,          0);
    add(0, 0, 0, 32'h0,        32'hABCD0001,  32'h00010104, 32'h00010100, 1, 32'hABCD0001, 1);
    add(0, 1, 1, 32'h00020000, 32'h0,         32'h00010104, 32'h00010100, 1, 32'hABCD0001, 1);
    add(0, 1, 1, 32'h00030000, 32'h0,         32'h00010104, 32'h00010100, 1, 32'hABCD0001, 1);
    add(0, 1, 0, 32'h0,        32'h0,         32'h00010104, 32'h00010100, 1, 32'hABCD0001, 1);
    add(0, 0, 0, 32'h0,        32'h77,        32'h00030000, 32'h0,        0, NOP,          0);
    add(0, 0, 0, 32'h0,        32'h11,        32'h00030004, 32'h00030000, 1, 32'h11,       1);
    add(0, 0, 1, 32'hFFFFFFFF, 32'h0,         32'hFFFFFFFC, 32'h00030004, 1, NOP,          0);
    add(0, 0, 0, 32'h0,        32'h22,        32'h00000000, 32'hFFFFFFFC, 1, 32'h22,       1);
    add(0, 1, 1, 32'h00020000, 32'h0,         32'h00000000, 32'hFFFFFFFC, 1, 32'h22,       1);
    add(1, 1, 0, 32'h0,        32'h0,         32'h00010000, 32'h00010000, 1, NOP,          0);
    add(0, 0, 0, 32'h0,        32'h93,        32'h00010004, 32'h00010000, 1, 32'h93,       1);
    add(0, 1, 1, 32'h00040000, 32'h0,         32'h00010004, 32'h00010000, 1, 32'h93,       1);
    add(0, 0, 1, 32'h00050002, 32'h0,         32'h00050000, 32'h0,        0, NOP,          0);
    add(0, 0, 0, 32'h0,        32'h33,        32'h00050004, 32'h00050000, 1, 32'h33,       1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].il, vecs[i].bt, vecs[i].tgt, vecs[i].data);
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      if (vecs[i].chk_pcid) chk($sformatf("vec%0d_pcid", i), bus.pc_if_id, vecs[i].e_pcid);
      chk($sformatf("vec%0d_inst", i), bus.inst_if_id, vecs[i].e_inst);
      chk($sformatf("vec%0d_valid", i), {31'h0, bus.valid_if_id}, {31'h0, vecs[i].e_valid});
    end

    model_step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic r, il, bt;
      logic [31:0] t, d;
      r  = ($urandom_range(0, 39) == 0);
      il = ($urandom_range(0, 2) == 0);
      bt = ($urandom_range(0, 3) == 0);
      t  = $urandom();
      d  = $urandom();
      model_step(r, il, bt, t, d);
      drive(r, il, bt, t, d);
      chk($sformatf("rnd%0d_addr", n), bus.imem_addr, m_pc);
      if (m_pcid_known) chk($sformatf("rnd%0d_pcid", n), bus.pc_if_id, m_pcid);
      chk($sformatf("rnd%0d_inst", n), bus.inst_if_id, m_inst);
      chk($sformatf("rnd%0d_valid", n), {31'h0, bus.valid_if_id}, {31'h0, m_valid});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
